shift_rx: RTL and testbench

SHIFT_RX -- requirements
Module: shift_rx

---
 rtl/shift_rx.sv | 95 +++++++++
 tb/tb_shift_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rx.sv
// Serial-to-parallel receiver: collects W bits MSB- or LSB-first into a word,
// then hands the word out through a valid/ready register with a sticky overrun flag.
module shift_rx #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  input  logic                 bit_valid,
  input  logic                 msb_first,
  input  logic                 clear,
  input  logic                 word_ready,
  output logic [W-1:0]         word_out,
  output logic                 word_valid,
  output logic                 overrun,
  output logic                 busy,
  output logic [$clog2(W)-1:0] bit_count
);

  localparam int CW = $clog2(W);

  typedef enum logic {IDLE, RECV} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   sh, sh_nxt, shifted, word_nxt;
  logic [CW-1:0]  cnt_nxt;
  logic           order, order_nxt, eff_order;
  logic           valid_nxt, ovr_nxt, last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh         <= '0;
      bit_count  <= '0;
      order      <= 1'b1;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sh         <= sh_nxt;
      bit_count  <= cnt_nxt;
      order      <= order_nxt;
      word_out   <= word_nxt;
      word_valid <= valid_nxt;
      overrun    <= ovr_nxt;
    end
  end

  // The first bit of a word uses the live msb_first; later bits use the latched order.
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = bit_count;
    order_nxt = order;
    word_nxt  = word_out;
    valid_nxt = word_valid;
    ovr_nxt   = overrun;
    eff_order = (state == IDLE) ? msb_first : order;
    last_bit  = (bit_count == CW'(W - 1));
    shifted   = eff_order ? {sh[W-2:0], serial_in} : {serial_in, sh[W-1:1]};

    if (clear) begin
      state_nxt = IDLE;
      sh_nxt    = '0;
      cnt_nxt   = '0;
      valid_nxt = 1'b0;
      ovr_nxt   = 1'b0;
    end else begin
      if (word_valid && word_ready)
        valid_nxt = 1'b0;
      if (bit_valid) begin
        sh_nxt    = shifted;
        order_nxt = eff_order;
        if (last_bit) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          // A pending word that is not being consumed this edge wins; the new one is lost.
          if (!word_valid || word_ready) begin
            word_nxt  = shifted;
            valid_nxt = 1'b1;
          end else begin
            ovr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt   = bit_count + CW'(1);
          state_nxt = RECV;
        end
      end
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_shift_rx.sv
// Scoreboard bench for shift_rx: a bit-list reference model pushes per-cycle
// expectations that a separate monitor pops and compares after each clock edge.
module tb_shift_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         serial_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         msb_first = 1'b1;
  logic         clear = 1'b0;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         overrun;
  logic         busy;
  logic [2:0]   bit_count;

  typedef struct {
    logic [W-1:0] word;
    logic         valid;
    logic         ovr;
    logic         busy;
    int           count;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;

  bit           m_bits[$];
  logic         m_order = 1'b1;
  logic [W-1:0] m_word = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;

  shift_rx #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .msb_first  (msb_first),
    .clear      (clear),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .overrun    (overrun),
    .busy       (busy),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: a word is just the list of received bits placed by order.
  task automatic modelStep(input logic s, input logic bv, input logic msb,
                           input logic clr, input logic rdy);
    logic [W-1:0] w;
    bit           done;
    exp_t         e;
    done = 0;
    w    = '0;
    if (clr) begin
      m_bits.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (bv) begin
        if (m_bits.size() == 0) m_order = msb;
        m_bits.push_back(s);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            if (m_order) w[W-1-i] = m_bits[i];
            else         w[i]     = m_bits[i];
          end
          m_bits.delete();
          done = 1;
        end
      end
      if (done) begin
        if (!m_valid || rdy) begin
          m_word  = w;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    e.word  = m_word;
    e.valid = m_valid;
    e.ovr   = m_ovr;
    e.busy  = (m_bits.size() != 0);
    e.count = m_bits.size();
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic s, input logic bv, input logic msb,
                               input logic clr, input logic rdy);
    @(negedge clk);
    serial_in  = s;
    bit_valid  = bv;
    msb_first  = msb;
    clear      = clr;
    word_ready = rdy;
    modelStep(s, bv, msb, clr, rdy);
  endtask

  // Bits go out pat[7] first; gap cycles drive the opposite order to exercise latching.
  task automatic sendBits(input logic [7:0] pat, input logic msb, input int gap,
                          input logic rdy, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(pat[i], 1'b1, msb, 1'b0, (i == 0) ? rdy_last : rdy);
      if (i != 0) repeat (gap) applyStimulus(1'b0, 1'b0, ~msb, 1'b0, rdy);
    end
  endtask

  task automatic observe();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_word_out", 32'(word_out), 32'(e.word));
        checkOutput("sb_word_valid", 32'(word_valid), 32'(e.valid));
        checkOutput("sb_overrun", 32'(overrun), 32'(e.ovr));
        checkOutput("sb_busy", 32'(busy), 32'(e.busy));
        checkOutput("sb_bit_count", 32'(bit_count), e.count);
      end
    end
  end

  initial begin : stimulus
    logic s, bv, msb, clr, rdy;
    #3;
    checkOutput("reset_word_out", 32'(word_out), 0);
    checkOutput("reset_word_valid", 32'(word_valid), 0);
    checkOutput("reset_overrun", 32'(overrun), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_bit_count", 32'(bit_count), 0);
    #4 rst_n = 1'b1;

    sendBits(8'h12, 1'b1, 0, 1'b0, 1'b0);
    observe();
    checkOutput("msb_word", 32'(word_out), 32'h12);
    checkOutput("msb_valid", 32'(word_valid), 1);
    checkOutput("msb_busy", 32'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    sendBits(8'h12, 1'b0, 0, 1'b0, 1'b0);
    observe();
    checkOutput("lsb_word", 32'(word_out), 32'h48);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    sendBits(8'h12, 1'b1, 3, 1'b0, 1'b0);
    observe();
    checkOutput("gap_word", 32'(word_out), 32'h12);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    sendBits(8'h12, 1'b1, 0, 1'b0, 1'b0);
    sendBits(8'hFF, 1'b1, 0, 1'b0, 1'b0);
    observe();
    checkOutput("ovr_word", 32'(word_out), 32'h12);
    checkOutput("ovr_flag", 32'(overrun), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    observe();
    checkOutput("clear_valid", 32'(word_valid), 0);
    checkOutput("clear_overrun", 32'(overrun), 0);
    checkOutput("clear_word_kept", 32'(word_out), 32'h12);

    sendBits(8'h12, 1'b1, 0, 1'b0, 1'b0);
    sendBits(8'hFF, 1'b1, 0, 1'b0, 1'b1);
    observe();
    checkOutput("hs_word", 32'(word_out), 32'hFF);
    checkOutput("hs_valid", 32'(word_valid), 1);
    checkOutput("hs_overrun", 32'(overrun), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      s   = 1'($urandom);
      bv  = ($urandom_range(9) < 6);
      msb = 1'($urandom);
      clr = ($urandom_range(39) == 0);
      rdy = ($urandom_range(9) < 4);
      applyStimulus(s, bv, msb, clr, rdy);
    end

    for (int n = 0; n < 5; n++)
      applyStimulus(1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
    observe();
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    clear     = 1'b0;
    m_bits.delete();
    m_order = 1'b1;
    m_word  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    #1;
    checkOutput("async_word_out", 32'(word_out), 0);
    checkOutput("async_word_valid", 32'(word_valid), 0);
    checkOutput("async_overrun", 32'(overrun), 0);
    checkOutput("async_busy", 32'(busy), 0);
    checkOutput("async_bit_count", 32'(bit_count), 0);
    #1 rst_n = 1'b1;
    sendBits(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    observe();
    checkOutput("post_reset_word", 32'(word_out), 32'hA5);
    checkOutput("post_reset_valid", 32'(word_valid), 1);
    checkOutput("post_reset_busy", 32'(busy), 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checkOutput("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
